// File: rtl/sram_sequencer.sv
// Purpose : sequences one bus request through address decode and the external SRAM strobes.
// Latency : strobe->done is 3+ACCESS_CYCLES clocks for SRAM cycles and 3 clocks for non-RAM cycles.
// Backpr. : none; a strobe while busy is dropped and flagged with a same-cycle overrun pulse.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   strobe, addr, we, wdata      one-clock request (accepted only in IDLE)
//   dec_addr                     latched address presented to the address decoder
//   ram_enable, is_readonly,     decoder outputs, sampled on the clock edge that ends DECODE
//   is_mirrored, io_enable
//   ram_addr, ram_ce_n, ram_oe_n,
//   ram_we_n, ram_dout,
//   ram_dout_oe, ram_din         external asynchronous SRAM interface
//   rdata                        last captured read data
//   done, busy, overrun          completion pulse, in-flight flag, dropped-request pulse
module sram_sequencer #(
  parameter int                    ADDR_WIDTH    = 17,
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    ACCESS_CYCLES = 2,
  parameter logic [ADDR_WIDTH-1:0] MIRROR_MASK   = 'h0C00
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  strobe,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [ADDR_WIDTH-1:0] dec_addr,
  input  logic                  ram_enable,
  input  logic                  is_readonly,
  input  logic                  is_mirrored,
  input  logic                  io_enable,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_ce_n,
  output logic                  ram_oe_n,
  output logic                  ram_we_n,
  output logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  ram_dout_oe,
  input  logic [DATA_WIDTH-1:0] ram_din,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  done,
  output logic                  busy,
  output logic                  overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SETUP,
    S_ACCESS,
    S_HOLD
  } state_t;

  localparam logic [3:0] LAST_ACC = 4'(ACCESS_CYCLES - 1);

  state_t                state;
  logic [3:0]            acc_cnt;
  logic                  req_we;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_ram;     // request targets SRAM
  logic                  req_wr_en;   // write that is allowed to pulse we_n

  // The only output that must react in the strobe's own cycle; derived from
  // the registered busy flag so it is glitch-free with respect to state.
  assign overrun = strobe & busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      acc_cnt     <= '0;
      req_we      <= 1'b0;
      req_wdata   <= '0;
      req_ram     <= 1'b0;
      req_wr_en   <= 1'b0;
      dec_addr    <= '0;
      ram_addr    <= '0;
      ram_ce_n    <= 1'b1;
      ram_oe_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      ram_dout    <= '0;
      ram_dout_oe <= 1'b0;
      rdata       <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (strobe) begin
            req_we    <= we;
            req_wdata <= wdata;
            dec_addr  <= addr;
            busy      <= 1'b1;
            state     <= S_DECODE;
          end
        end

        // Decoder outputs for dec_addr are valid by the end of this cycle; the
        // SETUP-cycle strobe values are registered from them on this edge so
        // that ce_n is already low while SETUP is visible.
        S_DECODE: begin
          state     <= S_SETUP;
          req_ram   <= ram_enable & ~io_enable;
          req_wr_en <= req_we & ~is_readonly;
          if (ram_enable && !io_enable) begin
            ram_addr <= is_mirrored ? (dec_addr & ~MIRROR_MASK) : dec_addr;
            ram_ce_n <= 1'b0;
            if (req_we) begin
              ram_dout    <= req_wdata;
              ram_dout_oe <= 1'b1;
            end else begin
              ram_oe_n <= 1'b0;
            end
          end
        end

        S_SETUP: begin
          if (req_ram) begin
            state    <= S_ACCESS;
            acc_cnt  <= '0;
            // ROM writes still run the full cycle, just without the we_n pulse.
            ram_we_n <= ~req_wr_en;
          end else begin
            state <= S_HOLD;
            done  <= 1'b1;
          end
        end

        S_ACCESS: begin
          if (acc_cnt == LAST_ACC) begin
            state    <= S_HOLD;
            ram_we_n <= 1'b1;
            ram_oe_n <= 1'b1;
            done     <= 1'b1;
            if (!req_we) begin
              rdata <= ram_din;
            end
          end else begin
            acc_cnt <= acc_cnt + 4'd1;
          end
        end

        // ce_n and the data drive stay asserted one more clock for write hold time.
        S_HOLD: begin
          state       <= S_IDLE;
          ram_ce_n    <= 1'b1;
          ram_dout_oe <= 1'b0;
          done        <= 1'b0;
          busy        <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_sequencer.sv
// Purpose : randomized and directed stimulus for sram_sequencer with a queue-based scoreboard.
// Latency : expected completion cycle is carried in each scoreboard entry.
// Backpr. : stimulus waits for idle between requests except where overrun is exercised.
module tb_sram_sequencer;
  localparam int AW = 17;
  localparam int DW = 8;
  localparam int AC = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          strobe = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          we = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [AW-1:0] dec_addr;
  logic          ram_enable, is_readonly, is_mirrored, io_enable;
  logic [AW-1:0] ram_addr;
  logic          ram_ce_n, ram_oe_n, ram_we_n, ram_dout_oe;
  logic [DW-1:0] ram_dout, ram_din, rdata;
  logic          done, busy, overrun;

  always #5 clk = ~clk;

  sram_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(AC), .MIRROR_MASK(17'h0C00)) dut (
    .clk(clk), .reset_n(reset_n), .strobe(strobe), .addr(addr), .we(we), .wdata(wdata),
    .dec_addr(dec_addr), .ram_enable(ram_enable), .is_readonly(is_readonly),
    .is_mirrored(is_mirrored), .io_enable(io_enable), .ram_addr(ram_addr),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_dout(ram_dout),
    .ram_dout_oe(ram_dout_oe), .ram_din(ram_din), .rdata(rdata), .done(done),
    .busy(busy), .overrun(overrun)
  );

  // Address map of the decoder stand-in: {ram_enable, is_readonly, is_mirrored, io_enable}
  //   E800-EFFF I/O, F000-FFFF ROM, 8000-8FFF mirrored VRAM, everything else RAM.
  function automatic logic [3:0] decode(input logic [AW-1:0] a);
    logic io, ro, mir;
    io  = !a[16] && (a[15:11] == 5'b11101);
    ro  = !a[16] && (a[15:12] == 4'hF);
    mir = !a[16] && (a[15:12] == 4'h8);
    return {!io, ro, mir, io};
  endfunction

  assign {ram_enable, is_readonly, is_mirrored, io_enable} = decode(dec_addr);

  // External SRAM
  logic [DW-1:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (reset_n && !ram_ce_n && !ram_we_n && ram_dout_oe) sram[ram_addr] = ram_dout;
  end
  assign ram_din = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr] : '0;

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_rdata = '0;

  typedef struct packed {
    int            t0;
    int            lat;
    logic          rd;
    logic [DW-1:0] rdata;
    int            ce_lo;
    int            oe_lo;
    int            we_lo;
    logic          chk_addr;
    logic [AW-1:0] addr;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives the strobe for the current cycle and records the expected outcome.
  task automatic start_req(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                           input logic commit);
    logic [3:0] dc;
    logic       is_ram, ro, mir;
    logic [AW-1:0] eff;
    exp_t e;
    strobe = 1'b1; addr = a; we = w; wdata = d;
    dc = decode(a);
    is_ram = dc[3]; ro = dc[2]; mir = dc[1];
    eff = mir ? (a & ~17'h0C00) : a;
    e.t0       = cyc;
    e.lat      = is_ram ? 3 + AC : 3;
    e.rd       = !w;
    e.ce_lo    = is_ram ? AC + 2 : 0;
    e.oe_lo    = (is_ram && !w) ? AC + 1 : 0;
    e.we_lo    = (is_ram && w && !ro) ? AC : 0;
    e.chk_addr = is_ram;
    e.addr     = eff;
    if (commit) begin
      if (is_ram && !w) ref_rdata = ref_mem[eff];
      if (is_ram && w && !ro) ref_mem[eff] = d;
      e.rdata = ref_rdata;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("idle_timeout", 1, 0);
  endtask

  task automatic do_req(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    @(posedge clk); #1;
    start_req(a, w, d, 1'b1);
    @(posedge clk); #1;
    strobe = 1'b0;
    wait_idle();
  endtask

  // Monitor: protocol invariants every cycle, scoreboard pop on each done.
  int   ce_cnt = 0, oe_cnt = 0, we_cnt = 0;
  logic addr_bad = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      ce_cnt = 0; oe_cnt = 0; we_cnt = 0; addr_bad = 1'b0;
    end else begin
      if (!ram_we_n || !ram_oe_n)
        chk("strobe_protocol", (!ram_we_n && !ram_oe_n) || (!ram_we_n && (ram_ce_n || !ram_dout_oe)), 0);
      if (!ram_ce_n) begin
        ce_cnt++;
        if (sb.size() > 0 && sb[0].chk_addr && ram_addr !== sb[0].addr) addr_bad = 1'b1;
      end
      if (!ram_oe_n) oe_cnt++;
      if (!ram_we_n) we_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc - e.t0, e.lat);
          chk("rdata", rdata, e.rdata);
          chk("ce_low_cycles", ce_cnt, e.ce_lo);
          chk("oe_low_cycles", oe_cnt, e.oe_lo);
          chk("we_low_cycles", we_cnt, e.we_lo);
          if (e.chk_addr) chk("ram_addr", addr_bad, 0);
        end
        ce_cnt = 0; oe_cnt = 0; we_cnt = 0; addr_bad = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v, orig;
    logic [AW-1:0] a;
    bit got;
    for (int i = 0; i < (1 << AW); i++) begin
      v = DW'($urandom);
      sram[i] = v;
      ref_mem[i] = v;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ce_n", ram_ce_n, 1);
    chk("rst_oe_n", ram_oe_n, 1);
    chk("rst_we_n", ram_we_n, 1);
    chk("rst_dout_oe", ram_dout_oe, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dec_addr", dec_addr, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_dout", ram_dout, 0);
    chk("rst_rdata", rdata, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Reset in the middle of a write's ACCESS phase
    a = 17'h01300;
    orig = ref_mem[a];
    @(posedge clk); #1 start_req(a, 1'b1, ~orig, 1'b0);
    @(posedge clk); #1 strobe = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("t1_we_active_before_reset", ram_we_n, 0);
    reset_n = 1'b0;
    #1;
    chk("t1_ce_n", ram_ce_n, 1);
    chk("t1_we_n", ram_we_n, 1);
    chk("t1_dout_oe", ram_dout_oe, 0);
    chk("t1_busy", busy, 0);
    repeat (3) begin
      @(negedge clk);
      chk("t1_no_done", done, 0);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    do_req(a, 1'b0, '0);
    chk("t1_no_partial_write", rdata, orig);

    // Plain read
    sram[17'h01234] = 8'hA5;
    ref_mem[17'h01234] = 8'hA5;
    do_req(17'h01234, 1'b0, '0);
    chk("t2_rdata", rdata, 8'hA5);

    // VRAM write with mirroring, then read through another alias
    do_req(17'h08C12, 1'b1, 8'h3C);
    do_req(17'h08412, 1'b0, '0);
    chk("t3_mirror_readback", rdata, 8'h3C);

    // ROM write is suppressed
    orig = ref_mem[17'h0F000];
    do_req(17'h0F000, 1'b1, ~orig);
    do_req(17'h0F000, 1'b0, '0);
    chk("t4_rom_unchanged", rdata, orig);

    // I/O read leaves rdata alone
    do_req(17'h0E812, 1'b0, '0);
    chk("t5_io_rdata", rdata, orig);

    // Overrun, then back-to-back acceptance right after done
    @(posedge clk); #1 start_req(17'h01234, 1'b0, '0, 1'b1);
    @(negedge clk); chk("t6_no_overrun_idle", overrun, 0);
    @(posedge clk); #1 strobe = 1'b0;
    @(posedge clk); #1 strobe = 1'b1; addr = 17'h01500; we = 1'b1; wdata = 8'hEE;
    @(negedge clk); chk("t6_overrun", overrun, 1);
    @(posedge clk); #1 strobe = 1'b0;
    @(negedge clk); chk("t6_overrun_pulse", overrun, 0);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("t6_done_seen", got, 1);
    @(posedge clk); #1 start_req(17'h01501, 1'b1, 8'h5A, 1'b1);
    @(posedge clk); #1 strobe = 1'b0;
    wait_idle();
    do_req(17'h01500, 1'b0, '0);
    do_req(17'h01501, 1'b0, '0);

    // Randomized traffic over a small address set so reads revisit writes
    for (int n = 0; n < 100; n++) begin
      case ($urandom % 5)
        0: a = 17'h01200;
        1: a = 17'h08000 + AW'(($urandom % 4) * 'h400);
        2: a = 17'h0F000;
        3: a = 17'h0E800;
        default: a = 17'h12340;
      endcase
      a = a + AW'($urandom % 16);
      repeat ($urandom % 3) @(posedge clk);
      do_req(a, 1'($urandom % 2), DW'($urandom));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
